mem_access_ctrl: RTL and testbench

- Data-memory access stage directly upstream of the load shifter.
- Accepts one load/store per handshake from EX, checks alignment, generates the word-aligned bus request with byte strobes and store-data alignment (SB/SH/SW/SWL/SWR), and waits for read data.
- Delivers raw word, addr[1:0], load_sel and rd to the load-shifter/WB side.
- Single outstanding transaction; backpressures EX while busy.

---
 rtl/mem_access_ctrl_pkg.sv | 57 +++++
 rtl/mem_access_ctrl_store_aligner.sv | 47 ++++
 rtl/mem_access_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access stage.
// Holds load/store op encodings (matching the load shifter's load_sel),
// the access FSM state encoding, address-error exception codes and the
// alignment-check helper used by the top level.
package mem_access_ctrl_pkg;

   // Load op encodings (identical to the load shifter's load_sel values)
   localparam logic [2:0] LOAD_LB  = 3'd0;
   localparam logic [2:0] LOAD_LBU = 3'd1;
   localparam logic [2:0] LOAD_LH  = 3'd2;
   localparam logic [2:0] LOAD_LHU = 3'd3;
   localparam logic [2:0] LOAD_LW  = 3'd4;
   localparam logic [2:0] LOAD_LWL = 3'd5;
   localparam logic [2:0] LOAD_LWR = 3'd6;

   // Store op encodings
   localparam logic [2:0] STORE_SB  = 3'd0;
   localparam logic [2:0] STORE_SH  = 3'd1;
   localparam logic [2:0] STORE_SW  = 3'd2;
   localparam logic [2:0] STORE_SWL = 3'd3;
   localparam logic [2:0] STORE_SWR = 3'd4;

   // Address-error exception codes
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   // Alignment check on the raw address; unused op codes behave as LW/SW,
   // and the unaligned-word ops (LWL/LWR/SWL/SWR) can never fault.
   function automatic logic addr_misaligned(input logic is_store,
                                            input logic [2:0] op,
                                            input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (is_store) begin
         case (op)
            STORE_SB, STORE_SWL, STORE_SWR: bad = 1'b0;
            STORE_SH:                       bad = addr_lo[0];
            default:                        bad = (addr_lo != 2'b00);
         endcase
      end else begin
         case (op)
            LOAD_LB, LOAD_LBU, LOAD_LWL, LOAD_LWR: bad = 1'b0;
            LOAD_LH, LOAD_LHU:                     bad = addr_lo[0];
            default:                               bad = (addr_lo != 2'b00);
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_store_aligner.sv
// Combinational store lane aligner: the mirror image of the load shifter.
// Ports:
//   op        in  3   store op (SB/SH/SW/SWL/SWR; 5..7 behave as SW)
//   byte_sel  in  2   byte lane select (address low bits, endian-adjusted)
//   wdata     in  32  rt value
//   wstrb     out 4   byte enables
//   wdata_al  out 32  lane-aligned store data
module store_aligner
   import mem_access_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  byte_sel,
   input  logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_al
);

   // Strobe and data lane selection per store op.
   // For SWL the shift is (3-bs) bytes; with a 2-bit bs, 3-bs == ~bs.
   always_comb begin
      wstrb    = 4'b0000;
      wdata_al = 32'h0000_0000;
      case (op)
         STORE_SB: begin
            wstrb    = 4'b0001 << byte_sel;
            wdata_al = {4{wdata[7:0]}};
         end
         STORE_SH: begin
            wstrb    = byte_sel[1] ? 4'b1100 : 4'b0011;
            wdata_al = {2{wdata[15:0]}};
         end
         STORE_SWL: begin
            wstrb    = 4'b1111 >> (~byte_sel);
            wdata_al = wdata >> {~byte_sel, 3'b000};
         end
         STORE_SWR: begin
            wstrb    = 4'b1111 << byte_sel;
            wdata_al = wdata << {byte_sel, 3'b000};
         end
         default: begin
            wstrb    = 4'b1111;
            wdata_al = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access stage upstream of the load shifter.
// Takes one load/store per EX handshake, checks alignment, issues a
// word-aligned bus request with strobes and aligned store data, waits for
// read data and hands the raw word plus addr_lo/load_sel/rd to WB.
// Single outstanding transaction; ex_ready is high only when idle.
// Ports:
//   clk, resetn (sync active-low)
//   ex_valid/ex_ready, ex_is_store, ex_op, ex_addr, ex_wdata, ex_rd : EX side
//   req_valid/req_ready, req_wr, req_addr, req_wstrb, req_wdata     : bus request
//   resp_valid, resp_rdata                                          : bus read data
//   wb_valid/wb_ready, wb_addr_lo, wb_load_sel, wb_mem_data, wb_rd  : WB side
//   exc_valid, exc_is_store, exc_badvaddr                           : address error
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int BIG_ENDIAN = 0
)(
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_is_store,
   input  logic [2:0]  ex_op,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [4:0]  ex_rd,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_wr,
   output logic [31:0] req_addr,
   output logic [3:0]  req_wstrb,
   output logic [31:0] req_wdata,
   input  logic        resp_valid,
   input  logic [31:0] resp_rdata,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [1:0]  wb_addr_lo,
   output logic [2:0]  wb_load_sel,
   output logic [31:0] wb_mem_data,
   output logic [4:0]  wb_rd,
   output logic        exc_valid,
   output logic        exc_is_store,
   output logic [31:0] exc_badvaddr
);

   localparam logic [1:0] ENDIAN_XOR = (BIG_ENDIAN != 0) ? 2'b11 : 2'b00;

   state_e      state_r;
   logic        ex_ready_r, req_valid_r, req_wr_r, wb_valid_r;
   logic        exc_valid_r, exc_is_store_r;
   logic [31:0] req_addr_r, req_wdata_r, wb_mem_data_r, exc_badvaddr_r;
   logic [3:0]  req_wstrb_r;
   logic [1:0]  wb_addr_lo_r;
   logic [2:0]  wb_load_sel_r;
   logic [4:0]  wb_rd_r;

   logic [1:0]  byte_sel_s;
   logic [3:0]  al_wstrb_s;
   logic [31:0] al_wdata_s;
   logic        misaligned_s;

   assign byte_sel_s   = ex_addr[1:0] ^ ENDIAN_XOR;
   assign misaligned_s = addr_misaligned(ex_is_store, ex_op, ex_addr[1:0]);

   store_aligner u_store_aligner (
      .op       (ex_op),
      .byte_sel (byte_sel_s),
      .wdata    (ex_wdata),
      .wstrb    (al_wstrb_s),
      .wdata_al (al_wdata_s)
   );

   // Access FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r        <= ST_IDLE;
         ex_ready_r     <= 1'b1;
         req_valid_r    <= 1'b0;
         req_wr_r       <= 1'b0;
         req_addr_r     <= 32'h0000_0000;
         req_wstrb_r    <= 4'b0000;
         req_wdata_r    <= 32'h0000_0000;
         wb_valid_r     <= 1'b0;
         wb_addr_lo_r   <= 2'b00;
         wb_load_sel_r  <= 3'd0;
         wb_mem_data_r  <= 32'h0000_0000;
         wb_rd_r        <= 5'd0;
         exc_valid_r    <= 1'b0;
         exc_is_store_r <= 1'b0;
         exc_badvaddr_r <= 32'h0000_0000;
      end else begin
         // exc_valid is a single-cycle pulse unless re-armed below
         exc_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (ex_valid) begin
                  if (misaligned_s) begin
                     exc_valid_r    <= 1'b1;
                     exc_is_store_r <= ex_is_store;
                     exc_badvaddr_r <= ex_addr;
                  end else begin
                     state_r     <= ST_REQ;
                     ex_ready_r  <= 1'b0;
                     req_valid_r <= 1'b1;
                     req_wr_r    <= ex_is_store;
                     req_addr_r  <= {ex_addr[31:2], 2'b00};
                     req_wstrb_r <= ex_is_store ? al_wstrb_s : 4'b0000;
                     req_wdata_r <= ex_is_store ? al_wdata_s : 32'h0000_0000;
                     if (!ex_is_store) begin
                        wb_addr_lo_r  <= ex_addr[1:0];
                        wb_load_sel_r <= ex_op;
                        wb_rd_r       <= ex_rd;
                     end
                  end
               end
            end
            ST_REQ: begin
               if (req_ready) begin
                  req_valid_r <= 1'b0;
                  if (req_wr_r) begin
                     // stores retire on acceptance
                     state_r    <= ST_IDLE;
                     ex_ready_r <= 1'b1;
                  end else begin
                     state_r <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (resp_valid) begin
                  wb_mem_data_r <= resp_rdata;
                  wb_valid_r    <= 1'b1;
                  state_r       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (wb_ready) begin
                  wb_valid_r <= 1'b0;
                  ex_ready_r <= 1'b1;
                  state_r    <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               ex_ready_r  <= 1'b1;
               req_valid_r <= 1'b0;
               wb_valid_r  <= 1'b0;
            end
         endcase
      end
   end

   assign ex_ready     = ex_ready_r;
   assign req_valid    = req_valid_r;
   assign req_wr       = req_wr_r;
   assign req_addr     = req_addr_r;
   assign req_wstrb    = req_wstrb_r;
   assign req_wdata    = req_wdata_r;
   assign wb_valid     = wb_valid_r;
   assign wb_addr_lo   = wb_addr_lo_r;
   assign wb_load_sel  = wb_load_sel_r;
   assign wb_mem_data  = wb_mem_data_r;
   assign wb_rd        = wb_rd_r;
   assign exc_valid    = exc_valid_r;
   assign exc_is_store = exc_is_store_r;
   assign exc_badvaddr = exc_badvaddr_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
// A little-endian and a big-endian instance share all inputs.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        resetn, ex_valid, ex_is_store, req_ready, resp_valid, wb_ready;
   logic [2:0]  ex_op;
   logic [31:0] ex_addr, ex_wdata, resp_rdata;
   logic [4:0]  ex_rd;

   logic        ex_ready, req_valid, req_wr, wb_valid, exc_valid, exc_is_store;
   logic [31:0] req_addr, req_wdata, wb_mem_data, exc_badvaddr;
   logic [3:0]  req_wstrb;
   logic [1:0]  wb_addr_lo;
   logic [2:0]  wb_load_sel;
   logic [4:0]  wb_rd;

   logic        be_ex_ready, be_req_valid, be_req_wr, be_wb_valid, be_exc_valid, be_exc_is_store;
   logic [31:0] be_req_addr, be_req_wdata, be_wb_mem_data, be_exc_badvaddr;
   logic [3:0]  be_req_wstrb;
   logic [1:0]  be_wb_addr_lo;
   logic [2:0]  be_wb_load_sel;
   logic [4:0]  be_wb_rd;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.BIG_ENDIAN(0)) dut (
      .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_is_store(ex_is_store), .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .ex_rd(ex_rd), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_addr_lo(wb_addr_lo), .wb_load_sel(wb_load_sel),
      .wb_mem_data(wb_mem_data), .wb_rd(wb_rd), .exc_valid(exc_valid),
      .exc_is_store(exc_is_store), .exc_badvaddr(exc_badvaddr)
   );

   mem_access_ctrl #(.BIG_ENDIAN(1)) dut_be (
      .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_ready(be_ex_ready),
      .ex_is_store(ex_is_store), .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .ex_rd(ex_rd), .req_valid(be_req_valid), .req_ready(req_ready), .req_wr(be_req_wr),
      .req_addr(be_req_addr), .req_wstrb(be_req_wstrb), .req_wdata(be_req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .wb_valid(be_wb_valid),
      .wb_ready(wb_ready), .wb_addr_lo(be_wb_addr_lo), .wb_load_sel(be_wb_load_sel),
      .wb_mem_data(be_wb_mem_data), .wb_rd(be_wb_rd), .exc_valid(be_exc_valid),
      .exc_is_store(be_exc_is_store), .exc_badvaddr(be_exc_badvaddr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one request for one cycle (IDLE accepts immediately)
   task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd);
      ex_valid = 1'b1; ex_is_store = st; ex_op = op; ex_addr = a; ex_wdata = d; ex_rd = rd;
      tick();
      ex_valid = 1'b0;
   endtask

   logic [3:0]  swl_strb [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
   logic [31:0] swl_data [4] = '{32'h0000_0011, 32'h0000_1122, 32'h0011_2233, 32'h1122_3344};
   logic [3:0]  swr_strb [4] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
   logic [31:0] swr_data [4] = '{32'h1122_3344, 32'h2233_4400, 32'h3344_0000, 32'h4400_0000};

   initial begin
      resetn = 1'b0; ex_valid = 1'b0; ex_is_store = 1'b0; ex_op = 3'd0;
      ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
      req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'h0; wb_ready = 1'b0;
      tick(); tick();
      resetn = 1'b1;

      // reset state
      chk("rst_ex_ready", ex_ready, 1);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_exc_valid", exc_valid, 0);
      chk("rst_req_wstrb", req_wstrb, 0);

      // LW best-case latency
      req_ready = 1'b1;
      issue(1'b0, 3'd4, 32'h1000_0004, 32'h0, 5'd7);
      chk("lw_req_valid", req_valid, 1);
      chk("lw_req_addr", req_addr, 32'h1000_0004);
      chk("lw_req_wstrb", req_wstrb, 0);
      chk("lw_req_wr", req_wr, 0);
      chk("lw_ex_ready", ex_ready, 0);
      tick();
      resp_valid = 1'b1; resp_rdata = 32'hDEAD_BEEF;
      chk("lw_c2_wb_valid", wb_valid, 0);
      tick();
      resp_valid = 1'b0;
      chk("lw_c3_wb_valid", wb_valid, 1);
      chk("lw_wb_data", wb_mem_data, 32'hDEAD_BEEF);
      chk("lw_wb_addr_lo", wb_addr_lo, 0);
      chk("lw_wb_load_sel", wb_load_sel, 4);
      chk("lw_wb_rd", wb_rd, 7);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("lw_done_wb_valid", wb_valid, 0);
      chk("lw_done_ex_ready", ex_ready, 1);

      // SB at 0x2003, both endiannesses
      issue(1'b1, 3'd0, 32'h0000_2003, 32'h0000_00A5, 5'd0);
      chk("sb_req_wr", req_wr, 1);
      chk("sb_wstrb_le", req_wstrb, 4'b1000);
      chk("sb_wdata", req_wdata, 32'hA5A5_A5A5);
      chk("sb_req_addr", req_addr, 32'h0000_2000);
      chk("sb_wstrb_be", be_req_wstrb, 4'b0001);
      tick();
      chk("sb_ex_ready", ex_ready, 1);
      chk("sb_req_valid_off", req_valid, 0);

      // SWL / SWR across all byte offsets; BE sees lane 3-i
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 3'd3, 32'h0000_4000 + i, 32'h1122_3344, 5'd0);
         chk("swl_wstrb", req_wstrb, swl_strb[i]);
         chk("swl_wdata", req_wdata, swl_data[i]);
         chk("swl_wstrb_be", be_req_wstrb, swl_strb[3-i]);
         tick();
         issue(1'b1, 3'd4, 32'h0000_4000 + i, 32'h1122_3344, 5'd0);
         chk("swr_wstrb", req_wstrb, swr_strb[i]);
         chk("swr_wdata", req_wdata, swr_data[i]);
         chk("swr_wdata_be", be_req_wdata, swr_data[3-i]);
         tick();
      end

      // unused store op 6 behaves as SW
      issue(1'b1, 3'd6, 32'h0000_7000, 32'h1234_5678, 5'd0);
      chk("op6_wstrb", req_wstrb, 4'b1111);
      chk("op6_wdata", req_wdata, 32'h1234_5678);
      tick();

      // misaligned LH
      issue(1'b0, 3'd2, 32'h0000_3001, 32'h0, 5'd1);
      chk("lh_exc_valid", exc_valid, 1);
      chk("lh_exc_is_store", exc_is_store, 0);
      chk("lh_badvaddr", exc_badvaddr, 32'h0000_3001);
      chk("lh_no_req", req_valid, 0);
      chk("lh_ex_ready", ex_ready, 1);
      tick();
      chk("lh_exc_pulse_end", exc_valid, 0);
      chk("lh_no_req_later", req_valid, 0);

      // misaligned SW
      issue(1'b1, 3'd2, 32'h0000_3002, 32'h0, 5'd0);
      chk("sw_exc_valid", exc_valid, 1);
      chk("sw_exc_is_store", exc_is_store, 1);
      chk("sw_badvaddr", exc_badvaddr, 32'h0000_3002);
      chk("sw_no_req", req_valid, 0);
      tick();
      chk("sw_exc_pulse_end", exc_valid, 0);

      // unused load op 7 behaves as LW: misaligned at offset 1
      issue(1'b0, 3'd7, 32'h0000_7001, 32'h0, 5'd0);
      chk("op7_exc_valid", exc_valid, 1);
      tick();

      // backpressure on request then on write-back
      req_ready = 1'b0;
      issue(1'b0, 3'd3, 32'h0000_5002, 32'h0, 5'd3);
      for (int k = 0; k < 3; k++) begin
         chk("bp_req_valid", req_valid, 1);
         chk("bp_req_addr", req_addr, 32'h0000_5000);
         chk("bp_ex_ready", ex_ready, 0);
         tick();
      end
      req_ready = 1'b1;
      chk("bp_req_valid_acc", req_valid, 1);
      tick();
      req_ready = 1'b0;
      chk("bp_req_dropped", req_valid, 0);
      resp_valid = 1'b1; resp_rdata = 32'hCAFE_F00D;
      tick();
      resp_valid = 1'b0; resp_rdata = 32'h0;
      for (int k = 0; k < 2; k++) begin
         chk("bp_wb_valid", wb_valid, 1);
         chk("bp_wb_data", wb_mem_data, 32'hCAFE_F00D);
         chk("bp_wb_addr_lo", wb_addr_lo, 2);
         chk("bp_wb_load_sel", wb_load_sel, 3);
         chk("bp_wb_rd", wb_rd, 3);
         chk("bp_wb_ex_ready", ex_ready, 0);
         tick();
      end
      wb_ready = 1'b1;
      chk("bp_wb_valid_acc", wb_valid, 1);
      tick();
      wb_ready = 1'b0;
      chk("bp_wb_done", wb_valid, 0);
      chk("bp_ex_ready_back", ex_ready, 1);

      // reset in WAIT, then a stale response
      req_ready = 1'b1;
      issue(1'b0, 3'd4, 32'h0000_6000, 32'h0, 5'd9);
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      chk("rw_ex_ready", ex_ready, 1);
      chk("rw_req_valid", req_valid, 0);
      resp_valid = 1'b1; resp_rdata = 32'h5555_AAAA;
      tick();
      resp_valid = 1'b0;
      chk("rw_wb_valid", wb_valid, 0);
      chk("rw_ex_ready2", ex_ready, 1);
      tick();
      chk("rw_wb_valid2", wb_valid, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
